left_lshifter_64: RTL and testbench

- 64-bit logical left shifter for the RV64 ALU; implements SLL/SLLI semantics.
- Combinational result `s` is available in the same cycle as the operands.
- A registered copy `s_q` is provided for pipelined consumers.
- Built as a 6-stage logarithmic barrel shifter.

---
 rtl/shifter_pkg.sv | 15 +
 rtl/left_lshifter_64_lshift_stage.sv | 20 ++
 rtl/left_lshifter_64.sv | 57 +++++
 tb/tb_left_lshifter_64.sv | 135 +++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shifter_pkg : shared widths and types for the 64-bit left shifter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package shifter_pkg;

  localparam int WIDTH   = 64;
  localparam int SHAMT_W = 6;

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

endpackage
`default_nettype wire

// File: rtl/left_lshifter_64_lshift_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lshift_stage : one barrel level, passes or shifts left by STEP       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lshift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = shifter_pkg::WIDTH,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? (in << STEP) : in;

endmodule
`default_nettype wire

// File: rtl/left_lshifter_64.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | left_lshifter_64 : RV64 SLL barrel shifter with registered copy      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module left_lshifter_64
  import shifter_pkg::*;
#(
  parameter int WIDTH   = shifter_pkg::WIDTH,
  parameter int SHAMT_W = shifter_pkg::SHAMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_q,
  output logic             s_q_valid
);

  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_stage [0:SHAMT_W];
  logic               w_unused_b;

  // Only the low shift-amount bits matter; the rest are folded into a
  // deliberately unused wire.
  assign w_shamt    = b[SHAMT_W-1:0];
  assign w_unused_b = ^b[WIDTH-1:SHAMT_W];
  assign w_stage[0] = a;

  generate
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      lshift_stage #(
        .WIDTH (WIDTH),
        .STEP  (1 << k)
      ) u_stage (
        .in  (w_stage[k]),
        .sel (w_shamt[k]),
        .out (w_stage[k+1])
      );
    end
  endgenerate

  assign s = w_stage[SHAMT_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q       <= '0;
      s_q_valid <= 1'b0;
    end else begin
      s_q       <= s;
      s_q_valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_left_lshifter_64.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_left_lshifter_64 : directed self-checking bench with scoreboard   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_left_lshifter_64;

  logic        clk;
  logic        reset;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] s;
  logic [63:0] s_q;
  logic        s_q_valid;

  int checks;
  int errors;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } exp_t;

  exp_t sb_q[$];

  left_lshifter_64 dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .s         (s),
    .s_q       (s_q),
    .s_q_valid (s_q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Bit-by-bit reference of SLL, independent of the shift operator.
  function automatic logic [63:0] model_sll(input logic [63:0] av, input logic [63:0] bv);
    logic [63:0] r;
    int sh;
    sh = int'(bv[5:0]);
    for (int i = 0; i < 64; i++)
      r[i] = (i >= sh) ? av[i-sh] : 1'b0;
    return r;
  endfunction

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: check s combinationally, queue the registered
  // expectation, then pop and compare it after the edge.
  task automatic step(input logic [63:0] av, input logic [63:0] bv,
                      input logic rv, input logic [63:0] s_exp);
    exp_t e;
    exp_t got;
    a     = av;
    b     = bv;
    reset = rv;
    #1;
    check64("s_comb", s, s_exp);
    check64("s_model", s, model_sll(av, bv));
    e.valid = ~rv;
    e.data  = rv ? 64'd0 : s_exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check64("s_q", s_q, got.data);
    checks++;
    assert (s_q_valid === got.valid) else begin
      errors++;
      $error("FAIL s_q_valid observed=%b expected=%b", s_q_valid, got.valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    a      = '0;
    b      = '0;
    @(posedge clk);
    #1;

    // Reset held two cycles; s still tracks inputs.
    step(64'h0000_0000_0000_1234, 64'd5, 1'b1, 64'h0000_0000_0002_4680);
    step(64'h0000_0000_0000_1234, 64'd5, 1'b1, 64'h0000_0000_0002_4680);

    step(64'd3, 64'd2, 1'b0, 64'd12);

    for (int i = 0; i < 64; i++) begin
      logic [63:0] one_hot;
      one_hot    = '0;
      one_hot[i] = 1'b1;
      step(64'd1, 64'(i), 1'b0, one_hot);
    end

    step(64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 1'b0, 64'h8000_0000_0000_0000);
    step(64'hFFFF_FFFF_FFFF_FFFF, 64'd0,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    step(64'h0123_4567_89AB_CDEF, 64'd4,  1'b0, 64'h1234_5678_9ABC_DEF0);
    step(64'h0123_4567_89AB_CDEF, 64'd32, 1'b0, 64'h89AB_CDEF_0000_0000);
    step(64'h0123_4567_89AB_CDEF, 64'd63, 1'b0, 64'h8000_0000_0000_0000);
    step(64'h0123_4567_89AB_CDEF, 64'd17, 1'b0, 64'h8ACF_1357_9BDE_0000);

    step(64'd1, 64'd64, 1'b0, 64'd1);
    step(64'd1, 64'hFFFF_FFFF_FFFF_FF41, 1'b0, 64'd2);

    step(64'd0, 64'd0,  1'b0, 64'd0);
    step(64'd0, 64'd31, 1'b0, 64'd0);
    step(64'd0, 64'd63, 1'b0, 64'd0);

    // Reset mid-stream: registered path clears, combinational path holds.
    step(64'd5, 64'd1, 1'b0, 64'd10);
    step(64'd5, 64'd1, 1'b1, 64'd10);
    step(64'd5, 64'd1, 1'b0, 64'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
